decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 174 +++++++++++++++++
 tb/tb_decode_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with format/immediate decode, flush and stall counter
// Optional skid entry: define DECODE_SKID_EN to register in_ready through a one-entry skid buffer.
module decode_stage #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic [31:0]          out_pc,
  output logic [2:0]           out_format,
  output logic [31:0]          out_imm,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [2:0] R_TYPE = 3'd0;
  localparam logic [2:0] I_TYPE = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] B_TYPE = 3'd3;
  localparam logic [2:0] U_TYPE = 3'd4;
  localparam logic [2:0] J_TYPE = 3'd5;

  logic [2:0]  dec_format;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic        in_fire;
  logic        out_free;

  // Classify the opcode of the offered instruction into a format
  always_comb begin
    dec_format  = R_TYPE;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      7'b0110111, 7'b0010111:                         dec_format = U_TYPE;
      7'b1101111:                                     dec_format = J_TYPE;
      7'b1100011:                                     dec_format = B_TYPE;
      7'b0100011:                                     dec_format = S_TYPE;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011:                         dec_format = I_TYPE;
      7'b0110011:                                     dec_format = R_TYPE;
      default: begin
        dec_format  = R_TYPE;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Form the sign-extended immediate for the decoded format
  always_comb begin
    dec_imm = 32'd0;
    case (dec_format)
      I_TYPE: dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
      S_TYPE: dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      B_TYPE: dec_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      U_TYPE: dec_imm = {in_inst[31:12], 12'd0};
      J_TYPE: dec_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default: dec_imm = 32'd0;
    endcase
  end

  // The output register may take a new entry when empty or being drained this cycle
  assign out_free = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

`ifdef DECODE_SKID_EN
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic [2:0]  skid_format;
  logic [31:0] skid_imm;
  logic        skid_illegal;

  // in_ready is the registered skid-empty bit, so out_ready never reaches it combinationally
  assign in_ready = !rst && !flush && !skid_valid;

  // Park an accepted instruction while the output stalls; release it on the next drain
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid   <= 1'b0;
      skid_inst    <= 32'd0;
      skid_pc      <= 32'd0;
      skid_format  <= R_TYPE;
      skid_imm     <= 32'd0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (in_fire && !out_free) begin
      skid_valid   <= 1'b1;
      skid_inst    <= in_inst;
      skid_pc      <= in_pc;
      skid_format  <= dec_format;
      skid_imm     <= dec_imm;
      skid_illegal <= dec_illegal;
    end else if (out_free && skid_valid) begin
      skid_valid <= 1'b0;
    end
  end

  // Output register: skid entry first to keep order, else the new input, else go empty
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_inst    <= 32'd0;
      out_pc      <= 32'd0;
      out_format  <= R_TYPE;
      out_imm     <= 32'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_inst    <= skid_inst;
        out_pc      <= skid_pc;
        out_format  <= skid_format;
        out_imm     <= skid_imm;
        out_illegal <= skid_illegal;
      end else if (in_fire) begin
        out_valid   <= 1'b1;
        out_inst    <= in_inst;
        out_pc      <= in_pc;
        out_format  <= dec_format;
        out_imm     <= dec_imm;
        out_illegal <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  // Accept only when the output register is free this cycle
  assign in_ready = !rst && !flush && out_free;

  // Output register: reload on acceptance, go empty when drained with nothing new
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_inst    <= 32'd0;
      out_pc      <= 32'd0;
      out_format  <= R_TYPE;
      out_imm     <= 32'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid   <= 1'b1;
      out_inst    <= in_inst;
      out_pc      <= in_pc;
      out_format  <= dec_format;
      out_imm     <= dec_imm;
      out_illegal <= dec_illegal;
    end else if (out_free) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // Count backpressure cycles, saturating; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (either DECODE_SKID_EN build)
module tb_decode_stage;

  localparam logic [31:0] R_T = 32'd0;
  localparam logic [31:0] I_T = 32'd1;
  localparam logic [31:0] S_T = 32'd2;
  localparam logic [31:0] B_T = 32'd3;
  localparam logic [31:0] U_T = 32'd4;
  localparam logic [31:0] J_T = 32'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_format;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  decode_stage #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_format(out_format), .out_imm(out_imm), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'd0; in_pc = 32'd0;
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_format", {29'd0, out_format}, R_T);
    check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // single decodes, streaming with out_ready high
    offer(32'hFFF00093, 32'h100);
    tick();
    check("i_valid", {31'd0, out_valid}, 32'd1);
    check("i_format", {29'd0, out_format}, I_T);
    check("i_imm", out_imm, 32'hFFFFFFFF);
    check("i_pc", out_pc, 32'h100);
    check("i_inst", out_inst, 32'hFFF00093);
    offer(32'h123452B7, 32'h104);
    tick();
    check("u_format", {29'd0, out_format}, U_T);
    check("u_imm", out_imm, 32'h12345000);
    offer(32'h008000EF, 32'h108);
    tick();
    check("j_format", {29'd0, out_format}, J_T);
    check("j_imm", out_imm, 32'h00000008);
    offer(32'h00112623, 32'h10C);
    tick();
    check("s_valid", {31'd0, out_valid}, 32'd1);
    check("s_format", {29'd0, out_format}, S_T);
    check("s_imm", out_imm, 32'h0000000C);
    offer(32'hFE000EE3, 32'h110);
    tick();
    check("b_valid", {31'd0, out_valid}, 32'd1);
    check("b_format", {29'd0, out_format}, B_T);
    check("b_imm", out_imm, 32'hFFFFFFFC);
    check("b_pc", out_pc, 32'h110);
    in_valid = 1'b0;
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // backpressure: A loaded, then three stalled edges
    out_ready = 1'b0;
    offer(32'h00000013, 32'h200);
    tick();
    check("bp_a_valid", {31'd0, out_valid}, 32'd1);
    offer(32'h00100093, 32'h204);
    #1;
`ifdef DECODE_SKID_EN
    check("bp_in_ready_skid_empty", {31'd0, in_ready}, 32'd1);
`else
    check("bp_in_ready_blocked", {31'd0, in_ready}, 32'd0);
`endif
    tick();
    check("bp_cnt1", {16'd0, stall_cnt}, 32'd1);
    check("bp_in_ready_after1", {31'd0, in_ready}, 32'd0);
`ifdef DECODE_SKID_EN
    offer(32'h00200093, 32'h208);
`endif
    tick();
    tick();
    check("bp_hold_inst", out_inst, 32'h00000013);
    check("bp_hold_pc", out_pc, 32'h200);
    check("bp_hold_imm", out_imm, 32'd0);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_cnt3", {16'd0, stall_cnt}, 32'd3);
    check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("rel_b_inst", out_inst, 32'h00100093);
    check("rel_b_imm", out_imm, 32'd1);
    check("rel_b_valid", {31'd0, out_valid}, 32'd1);
    check("rel_cnt", {16'd0, stall_cnt}, 32'd3);
`ifdef DECODE_SKID_EN
    check("rel_in_ready_rise", {31'd0, in_ready}, 32'd1);
    tick();
    check("rel_c_inst", out_inst, 32'h00200093);
    check("rel_c_imm", out_imm, 32'd2);
`endif
    in_valid = 1'b0;
    tick();
    check("rel_drain", {31'd0, out_valid}, 32'd0);

    // flush with output (and skid) full
    out_ready = 1'b0;
    offer(32'h00300093, 32'h300);
    tick();
    offer(32'h00400093, 32'h304);
    tick();
    check("fl_d_inst", out_inst, 32'h00300093);
    flush = 1'b1;
    offer(32'h00500093, 32'h308);
    #1;
    check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("fl_nothing_after", {31'd0, out_valid}, 32'd0);
    check("fl_cnt_kept", {16'd0, stall_cnt}, 32'd5);

    // illegal opcode, held under backpressure for the reset test
    out_ready = 1'b0;
    offer(32'h0000007F, 32'h400);
    tick();
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_format", {29'd0, out_format}, R_T);
    check("ill_imm", out_imm, 32'd0);
    check("ill_cnt", {16'd0, stall_cnt}, 32'd5);

    // reset mid-stall
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mr_in_ready_now", {31'd0, in_ready}, 32'd0);
    tick();
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_cnt", {16'd0, stall_cnt}, 32'd0);
    check("mr_illegal", {31'd0, out_illegal}, 32'd0);
    check("mr_inst", out_inst, 32'd0);
    tick();
    check("mr_in_ready_hold", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("mr_in_ready_release", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
